// File: rtl/asteroid_field.sv
// rtl/asteroid_field.sv - falling asteroid objects: spawn, motion, collisions, score and draw flags
//
// Ports:
//   clk, reset           pixel clock; asynchronous active-high reset
//   HCounter, VCounter   raster position from the counter generator
//   laser, laser_x       laser level and column, sampled on the frame tick
//   draw_red/green/blue  per-pixel layer flags, registered (one clk behind the counters)
//   planet_hit           one-cycle pulse after a tick where an asteroid reached the ground
//   score_inc            one-cycle pulse after a tick where the laser destroyed something
//   score, hits          destroyed-asteroid count (sat. 255) and planet-hit count (sat. 15)
//   game_over            sticky once hits reaches MAX_HITS; stops spawning
module asteroid_field #(
    parameter int NUM_AST        = 4,
    parameter int SPEED          = 2,
    parameter int SPAWN_FRAMES   = 60,
    parameter int EXPLODE_FRAMES = 8,
    parameter int GROUND_Y       = 436,
    parameter int MAX_HITS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] HCounter,
    input  logic [9:0] VCounter,
    input  logic       laser,
    input  logic [9:0] laser_x,
    output logic       draw_red,
    output logic       draw_green,
    output logic       draw_blue,
    output logic       planet_hit,
    output logic       score_inc,
    output logic [7:0] score,
    output logic [3:0] hits,
    output logic       game_over
);

    localparam int             CW         = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam int             IW         = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(SPAWN_FRAMES - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [10:0]    SPEED_W    = 11'(SPEED);
    localparam logic [9:0]     SPEED_10   = 10'(SPEED);
    localparam logic [10:0]    GROUND_TOP = 11'(GROUND_Y - 16);
    localparam logic [9:0]     GROUND_ROW = 10'(GROUND_Y - 16);
    localparam logic [3:0]     EXP_LOAD   = 4'(EXPLODE_FRAMES - 1);
    localparam logic [3:0]     HITS_LIMIT = 4'(MAX_HITS);

    typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, EXPLODE = 2'd2} slot_state_t;

    slot_state_t    st   [NUM_AST];
    logic [9:0]     ax   [NUM_AST];
    logic [9:0]     ay   [NUM_AST];
    logic [3:0]     ecnt [NUM_AST];
    logic [15:0]    lfsr;
    logic [CW-1:0]  spawn_cnt;

    logic               tick;
    logic               visible;
    logic               spawn_wrap;
    logic               spawn_ok;
    logic [IW-1:0]      spawn_idx;
    logic [NUM_AST-1:0] lhit;
    logic [NUM_AST-1:0] ghit;
    logic [NUM_AST-1:0] in_fall;
    logic [NUM_AST-1:0] in_expl;
    logic [8:0]         n_kill;
    logic [4:0]         n_ground;
    logic [8:0]         score_sum;
    logic [4:0]         hits_sum;
    logic [7:0]         score_next;
    logic [3:0]         hits_next;

    always_comb begin
        tick       = (HCounter == 10'd0) && (VCounter == 10'd0);
        visible    = (HCounter >= 10'd144) && (HCounter <= 10'd783) &&
                     (VCounter >= 10'd36)  && (VCounter <= 10'd515);
        spawn_wrap = (spawn_cnt == CNT_LAST);
        spawn_ok   = 1'b0;
        spawn_idx  = '0;
        lhit       = '0;
        ghit       = '0;
        in_fall    = '0;
        in_expl    = '0;
        n_kill     = '0;
        n_ground   = '0;
        // Descending scan so the lowest-index idle slot is the one left selected.
        for (int i = NUM_AST - 1; i >= 0; i--) begin
            if (st[i] == IDLE) begin
                spawn_ok  = 1'b1;
                spawn_idx = IW'(i);
            end
            lhit[i] = (st[i] == FALL) && laser && (laser_x >= ax[i]) &&
                      ({1'b0, laser_x} <= {1'b0, ax[i]} + 11'd15);
            // Laser takes priority over the ground on the same tick.
            ghit[i] = (st[i] == FALL) && !lhit[i] &&
                      ({1'b0, ay[i]} + SPEED_W >= GROUND_TOP);
            if ((HCounter >= ax[i]) && ({1'b0, HCounter} <= {1'b0, ax[i]} + 11'd15) &&
                (VCounter >= ay[i]) && ({1'b0, VCounter} <= {1'b0, ay[i]} + 11'd15)) begin
                in_fall[i] = (st[i] == FALL);
                in_expl[i] = (st[i] == EXPLODE);
            end
            n_kill   = n_kill + 9'(lhit[i]);
            n_ground = n_ground + 5'(ghit[i]);
        end
        score_sum  = {1'b0, score} + n_kill;
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
        hits_sum   = {1'b0, hits} + n_ground;
        hits_next  = hits_sum[4] ? 4'hF : hits_sum[3:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AST; i++) begin
                st[i]   <= IDLE;
                ax[i]   <= '0;
                ay[i]   <= '0;
                ecnt[i] <= '0;
            end
            lfsr       <= 16'hACE1;
            spawn_cnt  <= '0;
            score      <= '0;
            hits       <= '0;
            game_over  <= 1'b0;
            draw_red   <= 1'b0;
            draw_green <= 1'b0;
            draw_blue  <= 1'b0;
            planet_hit <= 1'b0;
            score_inc  <= 1'b0;
        end else begin
            draw_red   <= visible && ((|in_fall) || (|in_expl));
            draw_green <= visible && (|in_fall);
            draw_blue  <= 1'b0;
            planet_hit <= tick && (|ghit);
            score_inc  <= tick && (|lhit);
            if (tick) begin
                lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + CNT_ONE;
                score     <= score_next;
                hits      <= hits_next;
                game_over <= game_over || (hits_next >= HITS_LIMIT);
                for (int i = 0; i < NUM_AST; i++) begin
                    if (lhit[i]) begin
                        st[i]   <= EXPLODE;
                        ecnt[i] <= EXP_LOAD;
                    end else if (ghit[i]) begin
                        st[i]   <= EXPLODE;
                        ay[i]   <= GROUND_ROW;
                        ecnt[i] <= EXP_LOAD;
                    end else begin
                        case (st[i])
                            FALL:    ay[i] <= ay[i] + SPEED_10;
                            EXPLODE: begin
                                if (ecnt[i] == 4'd0) st[i] <= IDLE;
                                else                 ecnt[i] <= ecnt[i] - 4'd1;
                            end
                            default: begin
                                if (spawn_wrap && spawn_ok && !game_over && (spawn_idx == IW'(i))) begin
                                    st[i] <= FALL;
                                    ax[i] <= 10'd144 + {1'b0, lfsr[8:0]};
                                    ay[i] <= 10'd36;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_asteroid_field.sv
// tb/tb_asteroid_field.sv - randomized scoreboard bench for asteroid_field
module tb_asteroid_field;

    localparam int N      = 4;
    localparam int SPEED  = 2;
    localparam int SPAWN  = 12;
    localparam int EXPL   = 8;
    localparam int GROUND = 436;
    localparam int MAXH   = 3;
    localparam int EPISODES = 4;
    localparam int FRAMES   = 400;
    localparam int PROBES   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] HCounter = '0;
    logic [9:0] VCounter = '0;
    logic       laser = 1'b0;
    logic [9:0] laser_x = '0;
    logic       draw_red, draw_green, draw_blue, planet_hit, score_inc, game_over;
    logic [7:0] score;
    logic [3:0] hits;

    asteroid_field #(
        .NUM_AST(N), .SPEED(SPEED), .SPAWN_FRAMES(SPAWN),
        .EXPLODE_FRAMES(EXPL), .GROUND_Y(GROUND), .MAX_HITS(MAXH)
    ) dut (
        .clk(clk), .reset(reset), .HCounter(HCounter), .VCounter(VCounter),
        .laser(laser), .laser_x(laser_x),
        .draw_red(draw_red), .draw_green(draw_green), .draw_blue(draw_blue),
        .planet_hit(planet_hit), .score_inc(score_inc), .score(score),
        .hits(hits), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = falling, 2 = exploding.
    int m_st [N];
    int m_x  [N];
    int m_y  [N];
    int m_e  [N];
    int m_lfsr, m_cnt, m_score, m_hits;
    bit m_go;

    logic [17:0] exp_q[$];
    logic [17:0] mon_exp, mon_got;
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_e[i] = 0;
        end
        m_lfsr = 16'hACE1; m_cnt = 0; m_score = 0; m_hits = 0; m_go = 0;
    endfunction

    function automatic logic [17:0] model_cycle(int h, int v, bit las, int lx);
        bit r, g, ph, si, vis;
        int kills, grounds, fb;
        int nst [N];
        int nx  [N];
        int ny  [N];
        int ne  [N];
        r = 0; g = 0; ph = 0; si = 0; kills = 0; grounds = 0;
        vis = (h >= 144) && (h <= 783) && (v >= 36) && (v <= 515);
        for (int i = 0; i < N; i++) begin
            if (vis && m_st[i] != 0 && h >= m_x[i] && h <= m_x[i] + 15 &&
                v >= m_y[i] && v <= m_y[i] + 15) begin
                r = 1;
                if (m_st[i] == 1) g = 1;
            end
        end
        if (h == 0 && v == 0) begin
            nst = m_st; nx = m_x; ny = m_y; ne = m_e;
            for (int i = 0; i < N; i++) begin
                if (m_st[i] == 1) begin
                    if (las && lx >= m_x[i] && lx <= m_x[i] + 15) begin
                        nst[i] = 2; ne[i] = EXPL - 1; kills++;
                    end else if (m_y[i] + SPEED >= GROUND - 16) begin
                        nst[i] = 2; ny[i] = GROUND - 16; ne[i] = EXPL - 1; grounds++;
                    end else begin
                        ny[i] = m_y[i] + SPEED;
                    end
                end else if (m_st[i] == 2) begin
                    if (m_e[i] == 0) nst[i] = 0;
                    else             ne[i] = m_e[i] - 1;
                end
            end
            if (m_cnt == SPAWN - 1) begin
                m_cnt = 0;
                if (!m_go) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_st[i] == 0) begin
                            nst[i] = 1; nx[i] = 144 + (m_lfsr & 511); ny[i] = 36;
                            break;
                        end
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_st = nst; m_x = nx; m_y = ny; m_e = ne;
            ph = (grounds > 0);
            si = (kills > 0);
            m_score = (m_score + kills > 255) ? 255 : m_score + kills;
            m_hits  = (m_hits + grounds > 15) ? 15 : m_hits + grounds;
            if (m_hits >= MAXH) m_go = 1;
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
        end
        return {r, g, 1'b0, ph, si, 8'(m_score), 4'(m_hits), m_go};
    endfunction

    task automatic drive_cycle(input bit rst, input int h, input int v, input bit las, input int lx);
        @(negedge clk);
        reset    = rst;
        HCounter = 10'(h);
        VCounter = 10'(v);
        laser    = las;
        laser_x  = 10'(lx);
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(model_cycle(h, v, las, lx));
        end
    endtask

    task automatic check_zero(input string name);
        logic [17:0] got;
        got = {draw_red, draw_green, draw_blue, planet_hit, score_inc, score, hits, game_over};
        n_vec++;
        if (got !== 18'h0)
            $display("FAIL %s: outputs=%05h required=00000", name, got);
        if (got !== 18'h0) n_bad++;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
    endtask

    task automatic run_frame(input int ep);
        bit las;
        int lx, tgt, h, v, pick;
        int cand[$];
        int near[$];
        int act[$];
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) begin
                cand.push_back(i);
                if (m_y[i] + SPEED >= GROUND - 16) near.push_back(i);
            end
        end
        las = 0;
        lx  = int'($urandom_range(0, 799));
        if (ep > 0) begin
            if (near.size() > 0 && $urandom_range(0, 1) == 1) begin
                tgt = near[$urandom_range(0, near.size() - 1)];
                las = 1;
                lx  = m_x[tgt] + int'($urandom_range(0, 17)) - 1;
            end else if (cand.size() > 0 && $urandom_range(0, 8 - 2 * ep) == 0) begin
                tgt = cand[$urandom_range(0, cand.size() - 1)];
                las = 1;
                lx  = m_x[tgt] + int'($urandom_range(0, 17)) - 1;
            end else begin
                las = ($urandom_range(0, 9) == 0);
            end
        end
        drive_cycle(0, 0, 0, las, lx);
        for (int k = 0; k < PROBES; k++) begin
            act.delete();
            for (int i = 0; i < N; i++) if (m_st[i] != 0) act.push_back(i);
            if (act.size() > 0 && $urandom_range(0, 3) != 0) begin
                pick = act[$urandom_range(0, act.size() - 1)];
                h = m_x[pick] + int'($urandom_range(0, 17)) - 1;
                v = m_y[pick] + int'($urandom_range(0, 17)) - 1;
            end else begin
                h = int'($urandom_range(1, 799));
                v = int'($urandom_range(0, 524));
            end
            drive_cycle(0, h, v, las, lx);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {draw_red, draw_green, draw_blue, planet_hit, score_inc, score, hits, game_over};
            cyc++;
            n_vec++;
            if (mon_got !== mon_exp) begin
                n_bad++;
                $display("FAIL cycle %0d: got r%0b g%0b b%0b ph%0b si%0b score=%0d hits=%0d go=%0b, want r%0b g%0b b%0b ph%0b si%0b score=%0d hits=%0d go=%0b",
                         cyc, mon_got[17], mon_got[16], mon_got[15], mon_got[14], mon_got[13],
                         mon_got[12:5], mon_got[4:1], mon_got[0],
                         mon_exp[17], mon_exp[16], mon_exp[15], mon_exp[14], mon_exp[13],
                         mon_exp[12:5], mon_exp[4:1], mon_exp[0]);
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0, 0);
        check_zero("reset_state");
        for (int ep = 0; ep < EPISODES; ep++) begin
            for (int f = 0; f < FRAMES; f++) run_frame(ep);
            async_reset();
            for (int i = 0; i < 2; i++) drive_cycle(1, 0, 0, 0, 0);
        end
        drive_cycle(0, 5, 5, 0, 0);
        drive_cycle(0, 5, 6, 0, 0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
